// File: rtl/bitscan_pkg.sv
// ============================================================================
// Module  : bitscan_pkg
// Brief   : Shared FSM state type and index-width helper for bitscan_encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bitscan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Index width for an n-bit vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ffs_n.sv
// ============================================================================
// Module  : ffs_n
// Brief   : Combinational find-first-set over N bits with selectable priority,
//           plus a flag that is high when exactly one bit is set.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ffs_n
  import bitscan_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int W        = idx_width(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         single
);

  // Later loop iterations overwrite earlier ones, so the scan direction
  // decides which set bit wins.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (vec[i]) idx = W'(i);
        end
      end
    end else begin : g_msb_first
      always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
          if (vec[i]) idx = W'(i);
        end
      end
    end
  endgenerate

  assign single = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/bitscan_encoder.sv
// ============================================================================
// Module  : bitscan_encoder
// Brief   : Registered bit-scan encoder; reports the index of every set bit of
//           an accepted vector, one index per output handshake.
//           Optional: BITSCAN_ENC_ZERO_REPORT_EN (all-zero vector -> one beat).
// Revision: 1.0
// ============================================================================
`default_nettype none

module bitscan_encoder
  import bitscan_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int W        = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_zero
);

  state_t         state, state_next;
  logic [N-1:0]   pending, pending_next;
  logic [N-1:0]   clr_mask;
  logic [W-1:0]   sel_idx;
  logic           sel_single;
  logic           accept;
  logic           fire;
  logic           zero_beat;

  ffs_n #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_ffs (
    .vec    (pending),
    .idx    (sel_idx),
    .single (sel_single)
  );

`ifdef BITSCAN_ENC_ZERO_REPORT_EN
  // An all-zero vector parks in SCAN with nothing pending for exactly one beat.
  assign zero_beat = (state == SCAN) && (pending == '0);
`else
  assign zero_beat = 1'b0;
`endif

  assign in_ready  = rst_n && en && (state == IDLE);
  assign out_valid = en && (state == SCAN);
  assign out_idx   = sel_idx;
  assign out_last  = sel_single || zero_beat;
  assign out_zero  = zero_beat;

  assign accept   = en && (state == IDLE) && in_valid;
  assign fire     = en && (state == SCAN) && out_ready;
  assign clr_mask = N'(1) << sel_idx;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    case (state)
      IDLE: begin
        if (accept) begin
          pending_next = in_vec;
`ifdef BITSCAN_ENC_ZERO_REPORT_EN
          state_next = SCAN;
`else
          if (in_vec != '0) state_next = SCAN;
`endif
        end
      end
      SCAN: begin
        if (fire) begin
          pending_next = pending & ~clr_mask;
          if (out_last) state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

endmodule

`default_nettype wire

// File: doc/bitscan_encoder.md
# bitscan_encoder

Parametrised, registered successor to the 8-to-3 encoder: accepts an N-bit request vector over a valid/ready handshake and emits the binary index of every set bit, one index per handshake, in a fixed priority order. Unlike the one-hot encoder, any number of bits may be set; each is reported once and then cleared. It sits between request-collection logic (interrupt lines, pending-flag registers) and a serial consumer that services one index at a time.

## Interface
- N, default 8: input vector width, N >= 2.
- LSB_FIRST, default 1: 1 = lowest set bit reported first; 0 = highest set bit first.
- W (localparam), = $clog2(N): index width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- en  in  1  block enable; low pauses all activity.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept a vector.
- in_vec  in  N  request vector.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer takes out_idx.
- out_idx  out  W  index of the currently selected bit.
- out_last  out  1  current index is the last for this vector.
- out_zero  out  1  current beat reports an all-zero vector (macro-dependent, see Configuration).

## Operation
- States: IDLE, SCAN.
- IDLE: in_ready = en. Accept when in_valid && in_ready: capture in_vec into pending register; nonzero -> SCAN.
- SCAN: in_ready = 0. out_valid = en. out_idx = priority index of first set bit in pending (per LSB_FIRST). out_last = 1 when pending has exactly one bit set.
- Handshake out_valid && out_ready: clear the reported bit in pending; if out_last -> IDLE, else remain in SCAN with next index.
- out_valid, once high, stays high with stable out_idx until handshake or en low.
- en low: in_ready = 0, out_valid = 0, pending and state held; resumes unchanged when en returns high.
- in_vec with all N bits set produces N beats, indices 0..N-1 (LSB_FIRST=1) or N-1..0 (LSB_FIRST=0).
- Index arithmetic: out_idx is unsigned W bits; N not a power of 2 never yields an index >= N.
- No combinational path from inputs to out_idx/out_last/out_zero; out_valid depends only on state and en.

## Timing
- Reset (rst_n low at a rising edge): state IDLE, pending 0, out_valid 0, out_idx 0, out_last 0, out_zero 0; in_ready 0 during reset cycle. Reset mid-scan discards remaining bits.
- Latency: vector accepted at edge k -> first out_valid at cycle after edge k.
- Throughput: one index per cycle while out_ready held high.
- One bubble cycle between vectors: in_ready rises the cycle after the out_last handshake.
- Simultaneous in_valid during SCAN is ignored (in_ready low); source must hold its vector.

## Configuration
- BITSCAN_ENC_ZERO_REPORT_EN defined: an accepted all-zero vector enters SCAN and produces one beat with out_valid=1, out_zero=1, out_last=1, out_idx=0; returns to IDLE on its handshake.
- Undefined: all-zero vectors are accepted and silently dropped (remain in IDLE, in_ready stays high next cycle); out_zero tied 0.

## Structure
- Package bitscan_pkg: state enum typedef (IDLE, SCAN), index-width helper function.
- Sub-module ffs_n: combinational find-first-set over N bits, parameter LSB_FIRST, outputs index and single-bit-remaining flag; instantiated once on pending.

## Test plan
- Reset then in_vec=8'b1010_0100, out_ready=1, LSB_FIRST=1 -> out_idx 2,5,7 on consecutive cycles, out_last only on 7, in_ready high one cycle later.
- Same vector, LSB_FIRST=0 -> out_idx 7,5,2.
- in_vec=8'hFF with out_ready toggled 1,0,1,... -> indices 0..7 each held stable while out_ready=0, eight handshakes total.
- en dropped for 3 cycles after second beat of 8'b1000_0011 -> out_valid low, then resumes with out_idx 7, out_last=1.
- rst_n low mid-scan of 8'h0F after index 1 -> all outputs 0 next cycle, in_ready high after release; new vector 8'h10 gives single beat idx 4.
- in_vec=8'h00 -> with macro: one beat out_zero=1, out_idx=0, out_last=1; without: no out_valid, in_ready stays high.
